frontend_detect_ctrl: RTL and testbench

FRONTEND_DETECT_CTRL -- requirements
Module: frontend_detect_ctrl

---
 rtl/frontend_detect_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_frontend_detect_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_detect_ctrl.sv
// frontend_detect_ctrl -- frontend plugin detection controller.
//
// Synchronizes the raw module ID pins and waits for the connector to settle.
// The ID is then sampled until NR_MATCH consecutive identical samples are seen.
// The confirmed ID is latched onto plugin_sel, and plugin IO is armed for two
// cycles before running. A plugin error, or an unplugged/unknown ID (all-zeros
// or all-ones), parks the block in a sticky FAULT state. rescan restarts the
// detection.
//
// Optional feature (macro FRONTEND_ID_WATCH_EN): hot-swap watch. When enabled,
// an ID that differs from plugin_sel for NR_MATCH consecutive cycles in RUN or
// FAULT restarts the detection.
//
// Ports:
//   clk, rst      : system clock and synchronous active-high reset
//   id_in         : raw module ID pins (asynchronous)
//   rescan        : single-cycle request to redo detection
//   plugin_error  : error flag from the selected plugin
//   plugin_sel    : latched ID selecting the plugin
//   plugin_en     : plugin IO enable (high only in RUN)
//   id_valid      : plugin_sel holds a confirmed ID
//   fault         : sticky fault flag
//   state_o       : FSM state (SETTLE=0 SAMPLE=1 ARM=2 RUN=3 FAULT=4)
module frontend_detect_ctrl #(
  parameter int ID_WIDTH      = 8,
  parameter int SETTLE_CYCLES = 1000,
  parameter int NR_MATCH      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] id_in,
  input  logic                rescan,
  input  logic                plugin_error,
  output logic [ID_WIDTH-1:0] plugin_sel,
  output logic                plugin_en,
  output logic                id_valid,
  output logic                fault,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    SETTLE = 3'd0,
    SAMPLE = 3'd1,
    ARM    = 3'd2,
    RUN    = 3'd3,
    FAULT  = 3'd4
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  MATCH_N     = 4'(NR_MATCH);

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] sync1_q, sync2_q;
  logic [ID_WIDTH-1:0] ref_q, ref_d, sel_q, sel_d;
  logic [1:0]          fill_q, fill_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [3:0]          match_q, match_d;
  logic                arm_q, arm_d;
  logic                valid_q, valid_d, fault_q, fault_d, en_q;
  logic                id_bad;
`ifdef FRONTEND_ID_WATCH_EN
  logic [3:0]          wcnt_q, wcnt_d;
`endif

  assign id_bad = (sel_q == '0) || (sel_q == '1);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    arm_d   = arm_q;
    valid_d = valid_q;
    fault_d = fault_q;
    // The synchronizer is cleared by reset, so its output is meaningless
    // until two edges have refilled it. Settling starts only after that.
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
`ifdef FRONTEND_ID_WATCH_EN
    wcnt_d  = '0;
`endif
    case (state_q)
      SETTLE: begin
        if (fill_q == 2'd2) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            ref_d   = sync2_q;
            match_d = 4'd1;
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      SAMPLE: begin
        if (match_q >= MATCH_N) begin
          sel_d   = ref_q;
          valid_d = 1'b1;
          arm_d   = 1'b0;
          state_d = ARM;
        end else if (sync2_q == ref_q) begin
          match_d = match_q + 4'd1;
        end else begin
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      ARM: begin
        if (!arm_q) begin
          arm_d = 1'b1;
        end else if (id_bad) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (plugin_error) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end
      FAULT: ;
      default: begin
        cnt_d   = '0;
        state_d = SETTLE;
      end
    endcase
`ifdef FRONTEND_ID_WATCH_EN
    if ((state_q == RUN || state_q == FAULT) && (sync2_q != sel_q)) begin
      if (({1'b0, wcnt_q} + 5'd1) >= 5'(NR_MATCH)) begin
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = SETTLE;
      end else begin
        wcnt_d = wcnt_q + 4'd1;
      end
    end
`endif
    // rescan beats every other transition (only rst is stronger)
    if (rescan) begin
      fault_d = 1'b0;
      valid_d = 1'b0;
      arm_d   = 1'b0;
      cnt_d   = '0;
      state_d = SETTLE;
`ifdef FRONTEND_ID_WATCH_EN
      wcnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SETTLE;
      sync1_q <= '0;
      sync2_q <= '0;
      ref_q   <= '0;
      sel_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= '0;
      arm_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      en_q    <= 1'b0;
`ifdef FRONTEND_ID_WATCH_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= id_in;
      sync2_q <= sync1_q;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      arm_q   <= arm_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      // Registered from the next state, so plugin_en falls on the same edge
      // that leaves RUN.
      en_q    <= (state_d == RUN);
`ifdef FRONTEND_ID_WATCH_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign plugin_sel = sel_q;
  assign plugin_en  = en_q;
  assign id_valid   = valid_q;
  assign fault      = fault_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_frontend_detect_ctrl.sv
// Testbench for frontend_detect_ctrl (SETTLE_CYCLES=10, NR_MATCH=3).
// Directed vector table, hand-written corner sequences and randomized IDs.
// The expected waveforms come from a timeline model: after a restart edge, plus
// `pre` edges of synchronizer refill after reset, the block settles for S
// edges, confirms the ID after N more edges, and arms for 2 edges.
module tb_frontend_detect_ctrl;
  localparam int S = 10;
  localparam int N = 3;
  localparam int T = S + N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] id_in = 8'h00;
  logic       rescan = 1'b0;
  logic       plugin_error = 1'b0;
  logic [7:0] plugin_sel;
  logic       plugin_en, id_valid, fault;
  logic [2:0] state_o;

  int tests = 0;
  int errs  = 0;
  logic [7:0] cur_sel = 8'h00;

  frontend_detect_ctrl #(.ID_WIDTH(8), .SETTLE_CYCLES(S), .NR_MATCH(N)) dut (
    .clk(clk), .rst(rst), .id_in(id_in), .rescan(rescan),
    .plugin_error(plugin_error), .plugin_sel(plugin_sel),
    .plugin_en(plugin_en), .id_valid(id_valid), .fault(fault),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse_rescan();
    rescan = 1'b1;
    step(1);
    rescan = 1'b0;
  endtask

  // The restart edge has just happened. Follow the timeline model for T+4
  // edges and check every output after each edge.
  task automatic detect(input logic [7:0] id, input int pre, input logic [7:0] prev);
    logic bad;
    logic [2:0] exp_st;
    int k;
    bad = (id == 8'h00) || (id == 8'hFF);
    for (int e = 1; e <= pre + T + 4; e++) begin
      step(1);
      k = e - pre;
      if (k < S)          exp_st = 3'd0;
      else if (k < T)     exp_st = 3'd1;
      else if (k < T + 2) exp_st = 3'd2;
      else                exp_st = bad ? 3'd4 : 3'd3;
      chk("det_state", state_o, exp_st);
      chk("det_valid", id_valid, k >= T);
      chk("det_en", plugin_en, (k >= T + 2) && !bad);
      chk("det_fault", fault, (k >= T + 2) && bad);
      chk("det_sel", plugin_sel, (k >= T) ? id : prev);
    end
    cur_sel = id;
  endtask

  typedef struct {
    logic [7:0] id;
    logic [7:0] exp_sel;
    logic [2:0] exp_state;
    logic       exp_en;
    logic       exp_fault;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int got;
    logic [7:0] rid;
    vecs[0] = '{8'h21, 8'h21, 3'd3, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 3'd4, 1'b0, 1'b1};
    vecs[2] = '{8'h5A, 8'h5A, 3'd3, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 3'd4, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 8'h01, 3'd3, 1'b1, 1'b0};
    vecs[5] = '{8'hFE, 8'hFE, 3'd3, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 3'd3, 1'b1, 1'b0};

    // reset state
    id_in = 8'h21;
    step(3);
    chk("rst_sel", plugin_sel, 8'h00);
    chk("rst_en", plugin_en, 1'b0);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_state", state_o, 3'd0);

    // detection from reset release: valid at edge 2+10+3, enable 2 later
    rst = 1'b0;
    detect(8'h21, 2, 8'h00);

    // single-cycle plugin error in RUN: sticky fault, then cleared by rescan
    plugin_error = 1'b1;
    step(1);
    plugin_error = 1'b0;
    chk("err_en", plugin_en, 1'b0);
    chk("err_fault", fault, 1'b1);
    chk("err_state", state_o, 3'd4);
    step(5);
    chk("err_hold", fault, 1'b1);
    chk("err_sel", plugin_sel, 8'h21);
    pulse_rescan();
    chk("rescan_fault", fault, 1'b0);
    chk("rescan_state", state_o, 3'd0);
    detect(8'h21, 0, cur_sel);

    // table-driven IDs, including the all-zeros and all-ones unplugged codes
    for (int i = 0; i < 7; i++) begin
      id_in = vecs[i].id;
      step(3);
      pulse_rescan();
      step(T + 3);
      chk("vec_sel", plugin_sel, vecs[i].exp_sel);
      chk("vec_state", state_o, vecs[i].exp_state);
      chk("vec_en", plugin_en, vecs[i].exp_en);
      chk("vec_fault", fault, vecs[i].exp_fault);
      chk("vec_valid", id_valid, 1'b1);
      cur_sel = vecs[i].exp_sel;
    end

    // ID toggling every cycle never confirms; a stable ID then does
    pulse_rescan();
    for (int i = 0; i < 40; i++) begin
      id_in = (i % 2 == 0) ? 8'h22 : 8'h21;
      step(1);
      chk("tog_en", plugin_en, 1'b0);
      chk("tog_valid", id_valid, 1'b0);
      chk("tog_state", {2'b00, state_o <= 3'd1}, 3'd1);
    end
    id_in = 8'h22;
    got = 0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      step(1);
      if (id_valid === 1'b1) got = 1;
    end
    chk("tog_confirm", got, 1);
    chk("tog_sel", plugin_sel, 8'h22);
    chk("tog_en_pre", plugin_en, 1'b0);
    step(2);
    chk("tog_en_run", plugin_en, 1'b1);
    cur_sel = 8'h22;

    // rescan and plugin_error together in RUN: rescan wins
    rescan = 1'b1;
    plugin_error = 1'b1;
    step(1);
    rescan = 1'b0;
    plugin_error = 1'b0;
    chk("both_state", state_o, 3'd0);
    chk("both_fault", fault, 1'b0);
    chk("both_en", plugin_en, 1'b0);
    chk("both_valid", id_valid, 1'b0);
    detect(8'h22, 0, cur_sel);

    // rst in RUN overrides a simultaneous rescan
    rst = 1'b1;
    rescan = 1'b1;
    step(1);
    rst = 1'b0;
    rescan = 1'b0;
    chk("mrst_state", state_o, 3'd0);
    chk("mrst_sel", plugin_sel, 8'h00);
    chk("mrst_en", plugin_en, 1'b0);
    chk("mrst_valid", id_valid, 1'b0);
    id_in = 8'h21;
    detect(8'h21, 2, 8'h00);

    // randomized IDs and error pulses against the timeline model
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 7))
        0: rid = 8'h00;
        1: rid = 8'hFF;
        default: rid = 8'($urandom_range(0, 255));
      endcase
      id_in = rid;
      step(3);
      pulse_rescan();
      detect(rid, 0, cur_sel);
      if (!(rid == 8'h00 || rid == 8'hFF)) begin
        step($urandom_range(0, 5));
        plugin_error = 1'b1;
        step(1);
        plugin_error = 1'b0;
        chk("rnd_err_fault", fault, 1'b1);
        chk("rnd_err_en", plugin_en, 1'b0);
        step($urandom_range(1, 6));
        chk("rnd_err_hold", state_o, 3'd4);
      end
    end

    // hot-swap of the module while running
    id_in = 8'h21;
    step(3);
    pulse_rescan();
    detect(8'h21, 0, cur_sel);
    id_in = 8'h30;
`ifdef FRONTEND_ID_WATCH_EN
    step(4);
    chk("watch_en_hold", plugin_en, 1'b1);
    step(1);
    chk("watch_en_drop", plugin_en, 1'b0);
    chk("watch_valid", id_valid, 1'b0);
    chk("watch_state", state_o, 3'd0);
    detect(8'h30, 0, 8'h21);
`else
    step(30);
    chk("nowatch_en", plugin_en, 1'b1);
    chk("nowatch_sel", plugin_sel, 8'h21);
    chk("nowatch_state", state_o, 3'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
